// File: rtl/tick_timer.sv
// tick_timer: programmable event timer counting upstream tick pulses.
// Emits a one-cycle expire pulse and sets a sticky irq when the period completes.
// Supports one-shot and periodic modes.
// Optional feature: define TICK_TIMER_CAPTURE_EN to add the count snapshot ports
// (cap_req, cap_val, cap_vld).
module tick_timer #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic             irq
`ifdef TICK_TIMER_CAPTURE_EN
    ,
    input  logic             cap_req,
    output logic [CNT_W-1:0] cap_val,
    output logic             cap_vld
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_d;
    logic             mode_q, mode_d;
    logic             expire_d;
    logic             irq_d;

    // Next-state and next-output decode; priority is stop > start > tick_in.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        count_d  = count;
        mode_d   = mode_q;
        expire_d = 1'b0;
        irq_d    = irq;

        // A zero period is meaningless, so it is stored as 1.
        if (cfg_we) begin
            period_d = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
        end

        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    mode_d  = mode;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    mode_d  = mode;
                    count_d = '0;
                end else if (tick_in) begin
                    // >= rather than == so a period shrunk mid-run still expires.
                    if (count >= period_q - CNT_W'(1)) begin
                        expire_d = 1'b1;
                        count_d  = '0;
                        if (!mode_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Setting by expiry wins over a simultaneous clear.
        if (expire_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // State and registered outputs; busy is decoded from the next state so it is a flop.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= CNT_W'(DEF_PERIOD);
            mode_q   <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            expire   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            count    <= count_d;
            busy     <= (state_d == RUN);
            expire   <= expire_d;
            irq      <= irq_d;
        end
    end

`ifdef TICK_TIMER_CAPTURE_EN
    // Snapshot of the count as it stood before this edge's update.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cap_val <= '0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= cap_req;
            if (cap_req) begin
                cap_val <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed scenarios followed by random stimulus, every cycle
// compared against a behavioural model of the timer.
module tb_tick_timer;

    localparam int CNT_W      = 16;
    localparam int DEF_PERIOD = 10;

    logic             clk_in = 1'b0;
    logic             rst = 1'b0;
    logic             tick_in = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             mode = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             irq_clr = 1'b0;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             expire;
    logic             irq;
`ifdef TICK_TIMER_CAPTURE_EN
    logic             cap_req = 1'b0;
    logic [CNT_W-1:0] cap_val;
    logic             cap_vld;
`endif

    tick_timer #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .tick_in   (tick_in),
        .cfg_we    (cfg_we),
        .cfg_period(cfg_period),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .irq_clr   (irq_clr),
        .count     (count),
        .busy      (busy),
        .expire    (expire),
        .irq       (irq)
`ifdef TICK_TIMER_CAPTURE_EN
        ,
        .cap_req   (cap_req),
        .cap_val   (cap_val),
        .cap_vld   (cap_vld)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: is the timer running, how many ticks it has seen,
    // how long the period is, and whether it repeats.
    bit          m_run;
    int unsigned m_cnt;
    int unsigned m_per;
    bit          m_periodic;
    bit          m_exp;
    bit          m_irq;
    int unsigned m_cv;
    bit          m_cvld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step();
        int unsigned per_now;
        per_now = m_per;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_per = DEF_PERIOD; m_periodic = 0;
            m_exp = 0; m_irq = 0; m_cv = 0; m_cvld = 0;
            return;
        end
`ifdef TICK_TIMER_CAPTURE_EN
        m_cvld = cap_req;
        if (cap_req) m_cv = m_cnt;
`endif
        m_exp = 0;
        if (stop) begin
            m_run = 0;
        end else if (start) begin
            m_run = 1; m_cnt = 0; m_periodic = mode;
        end else if (tick_in && m_run) begin
            // This tick completes the period when ticks seen reaches the period.
            if (m_cnt + 1 >= per_now) begin
                m_exp = 1;
                m_cnt = 0;
                if (!m_periodic) m_run = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (m_exp) m_irq = 1;
        else if (irq_clr) m_irq = 0;
        if (cfg_we) m_per = (cfg_period == 0) ? 1 : int'(cfg_period);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later, pulses dropped.
    task automatic cyc();
        @(posedge clk_in);
        model_step();
        #1;
        chk("count", 32'(count), m_cnt);
        chk("busy", 32'(busy), 32'(m_run));
        chk("expire", 32'(expire), 32'(m_exp));
        chk("irq", 32'(irq), 32'(m_irq));
`ifdef TICK_TIMER_CAPTURE_EN
        chk("cap_vld", 32'(cap_vld), 32'(m_cvld));
        chk("cap_val", 32'(cap_val), m_cv);
        cap_req = 0;
`endif
        rst = 0; tick_in = 0; cfg_we = 0; start = 0; stop = 0; irq_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // 1: reset, then a tick in IDLE is ignored
        rst = 1; cyc();
        rst = 1; cyc();
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expire", 32'(expire), 0);
        chk("rst_irq", 32'(irq), 0);
        tick_in = 1; cyc();
        chk("idle_tick_count", 32'(count), 0);

        // 2: periodic, period 3, tick every 5 cycles
        cfg_we = 1; cfg_period = 3; cyc();
        mode = 1; start = 1; cyc();
        for (int t = 1; t <= 6; t++) begin
            tick_in = 1; cyc();
            chk("per_count", 32'(count), 32'(t % 3));
            chk("per_expire", 32'(expire), (t % 3 == 0) ? 1 : 0);
            chk("per_busy", 32'(busy), 1);
            idle(4);
            chk("per_expire_gone", 32'(expire), 0);
        end
        chk("per_irq", 32'(irq), 1);

        // 3: one-shot, period 2, three ticks
        stop = 1; cyc();
        cfg_we = 1; cfg_period = 2; cyc();
        mode = 0; start = 1; cyc();
        tick_in = 1; cyc();
        chk("os_count1", 32'(count), 1);
        tick_in = 1; cyc();
        chk("os_expire", 32'(expire), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_count2", 32'(count), 0);
        tick_in = 1; cyc();
        chk("os_tick3_expire", 32'(expire), 0);
        chk("os_tick3_count", 32'(count), 0);

        // 4: stop together with a tick
        cfg_we = 1; cfg_period = 4; cyc();
        start = 1; cyc();
        tick_in = 1; cyc();
        tick_in = 1; cyc();
        stop = 1; tick_in = 1; cyc();
        chk("stop_busy", 32'(busy), 0);
        chk("stop_count", 32'(count), 2);
        chk("stop_expire", 32'(expire), 0);
        start = 1; cyc();
        chk("restart_count", 32'(count), 0);
        chk("restart_busy", 32'(busy), 1);

        // 5: irq_clr collides with expiry, then clears alone
        tick_in = 1; cyc();
        tick_in = 1; cyc();
        tick_in = 1; cyc();
        tick_in = 1; irq_clr = 1; cyc();
        chk("coll_expire", 32'(expire), 1);
        chk("coll_irq", 32'(irq), 1);
        irq_clr = 1; cyc();
        chk("clr_irq", 32'(irq), 0);

        // 6: zero period becomes 1; back-to-back ticks expire back-to-back
        cfg_we = 1; cfg_period = 0; cyc();
        mode = 1; start = 1; cyc();
        tick_in = 1; cyc();
        chk("p1_expire_a", 32'(expire), 1);
        tick_in = 1; cyc();
        chk("p1_expire_b", 32'(expire), 1);
        chk("p1_count", 32'(count), 0);
        cyc();
        chk("p1_expire_c", 32'(expire), 0);

`ifdef TICK_TIMER_CAPTURE_EN
        cfg_we = 1; cfg_period = 5; cyc();
        start = 1; cyc();
        tick_in = 1; cyc();
        tick_in = 1; cyc();
        cap_req = 1; cyc();
        chk("cap_val2", 32'(cap_val), 2);
        chk("cap_vld_on", 32'(cap_vld), 1);
        cyc();
        chk("cap_vld_off", 32'(cap_vld), 0);
`endif

        // Random phase: sparse controls, frequent ticks, small periods
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            tick_in = ($urandom_range(0, 2) == 0);
            start   = ($urandom_range(0, 24) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            irq_clr = ($urandom_range(0, 9) == 0);
            cfg_we  = ($urandom_range(0, 29) == 0);
            cfg_period = CNT_W'($urandom_range(0, 6));
            mode    = 1'($urandom_range(0, 1));
`ifdef TICK_TIMER_CAPTURE_EN
            cap_req = ($urandom_range(0, 7) == 0);
`endif
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
